// File: rtl/multi_mode_reduce_gate_if.sv
// Stream interface for the multi-mode reduction gate: beat input side and result output side.
interface multi_mode_reduce_gate_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_mask;
    logic [2:0]       in_op;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_result;
    logic [CNT_W-1:0] out_beats;
    logic             out_sat;

    modport master (
        output in_valid, in_data, in_mask, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_beats, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_op, in_last, out_ready,
        output in_ready, out_valid, out_result, out_beats, out_sat
    );
endinterface

// File: rtl/multi_mode_reduce_gate.sv
// Registered multi-beat reduction gate (AND/NAND/OR/NOR/XOR/XNOR) with per-bit masking,
// saturating beat counter and valid/ready handshakes on both sides.
module multi_mode_reduce_gate #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    multi_mode_reduce_gate_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic             acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    logic [2:0]       frame_op;
    logic             beat_r;
    logic             acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;
    logic             accept;

    // Masked-off bits are forced to the identity of the base op before reducing.
    function automatic logic reduce_beat(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                         input logic [WIDTH-1:0] m);
        case (op[2:1])
            2'b01:   return |(d & m);
            2'b10:   return ^(d & m);
            default: return &(d | ~m);
        endcase
    endfunction

    function automatic logic combine(input logic [2:0] op, input logic a, input logic b);
        case (op[2:1])
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // NAND, NOR, XNOR and the 11x codes invert the final accumulator.
    function automatic logic invert(input logic [2:0] op);
        return op[0] | (op[2] & op[1]);
    endfunction

    always_comb begin
        frame_op = op_q;
        acc_next = acc_q;
        cnt_next = cnt_q;
        sat_next = sat_q;
        accept   = bus.in_valid & bus.in_ready;
        if (state == IDLE) frame_op = bus.in_op;
        beat_r = reduce_beat(frame_op, bus.in_data, bus.in_mask);
        if (state == IDLE) begin
            acc_next = beat_r;
            cnt_next = CNT_W'(1);
            sat_next = 1'b0;
        end else begin
            acc_next = combine(frame_op, acc_q, beat_r);
            if (&cnt_q) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_q           <= 3'b000;
            acc_q          <= 1'b0;
            cnt_q          <= '0;
            sat_q          <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= 1'b0;
            bus.out_beats  <= '0;
            bus.out_sat    <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        op_q  <= frame_op;
                        acc_q <= acc_next;
                        cnt_q <= cnt_next;
                        sat_q <= sat_next;
                        if (bus.in_last) begin
                            state          <= HOLD;
                            bus.in_ready   <= 1'b0;
                            bus.out_valid  <= 1'b1;
                            bus.out_result <= acc_next ^ invert(frame_op);
                            bus.out_beats  <= cnt_next;
                            bus.out_sat    <= sat_next;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/multi_mode_reduce_gate.md
Name: multi_mode_reduce_gate

Overview:
- Parametrised successor to the fixed 4-input NAND gate.
- Reduces a WIDTH-bit word, or a multi-beat frame of words, with a selectable logic function: AND, NAND, OR, NOR, XOR or XNOR.
- Bits can be masked per beat; the result is registered.
- Valid/ready handshakes on both sides; used as a generic registered gate/reduction unit between streaming blocks.

Parameters:
- WIDTH, 4, input word width (gate input count per beat); >=1.
- CNT_W, 8, beat-counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat present.
- in_ready  output  1  block accepts beat.
- in_data  input  WIDTH  gate inputs for this beat.
- in_mask  input  WIDTH  1 = bit participates; 0 = bit replaced by identity.
- in_op  input  3  000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 11x treated as NAND.
- in_last  input  1  final beat of frame.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_result  output  1  reduced result of frame.
- out_beats  output  CNT_W  beats in frame (saturating).
- out_sat  output  1  beat count saturated during frame.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=0 while reset asserted, out_valid=0, out_result=0, out_beats=0, out_sat=0.
  - Accumulator and latched op cleared.
  - Reset mid-frame or mid-HOLD discards everything; no partial result is emitted.
- Accept: a beat is accepted when in_valid & in_ready on a rising edge.
- States: IDLE, ACCUM, HOLD.
  - in_ready=1 in IDLE and ACCUM after reset release; in_ready=0 in HOLD.
- IDLE, beat accepted:
  - Latch in_op (frame op); load accumulator with the per-beat reduction of the beat.
  - Count=1.
  - in_last=1 -> HOLD; else -> ACCUM.
- ACCUM, beat accepted:
  - Accumulator combined with the per-beat reduction using the base op.
  - Count incremented.
  - in_op on non-first beats is ignored.
  - in_last=1 -> HOLD.
- Per-beat reduction:
  - Masked-off bits take the base-op identity: 1 for AND-type, 0 for OR- and XOR-type.
  - Base op: AND for AND/NAND, OR for OR/NOR, XOR for XOR/XNOR.
- HOLD:
  - out_valid=1.
  - out_result = accumulator, inverted for NAND/NOR/XNOR/11x.
  - out_beats = count; out_sat = sticky saturation flag.
  - All outputs stable until out_valid & out_ready; then -> IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
- Latency: out_valid rises the cycle after the last beat is accepted (1 cycle). There is no bypass.
- Throughput: minimum one idle input cycle per frame, i.e. the HOLD cycle.
- Counter: saturates at 2^CNT_W-1; out_sat set when an accepted beat would exceed it. The accumulator keeps combining beyond saturation.
- All-masked frame: result is the identity, post-inversion: AND=1, NAND=0, OR=0, NOR=1, XOR=0, XNOR=1.
- in_valid=0 in ACCUM: state holds indefinitely; no timeout.
- out_result/out_beats/out_sat hold their last values in IDLE/ACCUM; they are qualified only by out_valid.
- WIDTH=1: the per-beat reduction is the masked bit itself.

Test Plan:
- WIDTH=4, single beat, op=NAND, data=1111, mask=1111, last=1, out_ready=1 -> out_valid one cycle after accept, out_result=0, out_beats=1. Repeat with data=1110 -> out_result=1.
- 3-beat XOR frame, data 1010/0111/0001, mask 1111, op changed to AND on beat 2 (must be ignored) -> beat parities 0,1,1 -> out_result=0, out_beats=3.
- NOR frame, beats data 0000 and 1000 with masks 1111 and 0111 -> out_result=1. Same frame with mask 1111 on beat 2 -> out_result=0.
- out_ready held 0 for 5 cycles in HOLD -> in_ready=0, outputs stable throughout. out_ready=1 -> IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
- CNT_W=2, 5-beat OR frame, all data 0 -> out_beats=3, out_sat=1, out_result=0. Next frame of 1 beat -> out_sat=0.
- Assert rst_n=0 asynchronously mid-ACCUM, then mid-HOLD -> out_valid=0 immediately; after release, a new 1-beat AND frame with data 1111 gives out_result=1, out_beats=1.
